// File: rtl/mer_pkg.sv
// Shared fixed-point widths, FSM encoding and slicer reference constant for the MER meter.
// Also holds the per-symbol term helpers so slicer-side blocks compute them identically.
package mer_pkg;

   localparam int DATA_W = 18;
   localparam int FRAC_W = 17;

   localparam logic signed [DATA_W-1:0] REF_INIT = 18'sd87381;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      LATCH = 2'd2
   } mer_state_t;

   // The most negative code has no positive twin in 1s17, so it clips to full scale.
   function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] r;
      if (x == {1'b1, {(DATA_W-1){1'b0}}})
         r = {1'b0, {(DATA_W-1){1'b1}}};
      else if (x[DATA_W-1])
         r = $unsigned(-x);
      else
         r = $unsigned(x);
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] sq_term(input logic signed [DATA_W-1:0] x);
      logic signed [2*DATA_W-1:0] p;
      p = x * x;
      return DATA_W'(p >> FRAC_W);
   endfunction

endpackage

// File: rtl/mer_accum.sv
// Unsigned window accumulator: load replaces the sum with din, clr zeroes it, en adds din.
// One-cycle update, no backpressure; priority is load > clr > en.
module mer_accum #(
   parameter int DIN_W = 18,
   parameter int ACC_W = 38
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic [DIN_W-1:0] din,
   output logic [ACC_W-1:0] acc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         acc <= '0;
      else if (load)
         acc <= ACC_W'(din);
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(din);
   end

endmodule

// File: rtl/mer_meter.sv
// Per-window mean |dec_var|, mean error^2 and symbol-error count; results pulse out one
// cycle after the LATCH state that follows the last accepted symbol. No backpressure.
module mer_meter #(
   parameter int WIN_LOG2 = 20,
   parameter logic signed [mer_pkg::DATA_W-1:0] REF_INIT = mer_pkg::REF_INIT
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               sym_clk_en,
   input  logic                               clear_accum,
   input  logic signed [mer_pkg::DATA_W-1:0]  dec_var,
   input  logic signed [mer_pkg::DATA_W-1:0]  error,
   input  logic                               sym_error,
   output logic signed [mer_pkg::DATA_W-1:0]  ref_level,
   output logic        [mer_pkg::DATA_W-1:0]  err_power,
   output logic        [WIN_LOG2:0]           sym_err_count,
   output logic                               result_valid,
   output logic                               busy
);
   import mer_pkg::*;

   localparam int ACC_W = DATA_W + WIN_LOG2;
   localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};
   localparam logic [WIN_LOG2:0]   ERR_MAX  = {1'b1, {WIN_LOG2{1'b0}}};

   mer_state_t state, state_nxt;
   logic start, add, latch, take;

   logic [DATA_W-1:0]   abs_val, sq_val;
   logic [ACC_W-1:0]    acc_abs, acc_sq;
   logic [WIN_LOG2-1:0] sym_cnt;
   logic [WIN_LOG2:0]   err_cnt;

   assign abs_val = abs_sat(dec_var);
   assign sq_val  = sq_term(error);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // start: a fresh window begins next cycle; take: this cycle's symbol seeds it.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      add       = 1'b0;
      latch     = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (clear_accum) begin
               start     = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            busy = 1'b1;
            if (clear_accum) begin
               start = 1'b1;
            end else if (sym_clk_en) begin
               add = 1'b1;
               if (sym_cnt == CNT_LAST)
                  state_nxt = LATCH;
            end
         end
         LATCH: begin
            busy      = 1'b1;
            start     = 1'b1;
            latch     = 1'b1;
            state_nxt = ACCUM;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign take = start & sym_clk_en;

   mer_accum #(.DIN_W(DATA_W), .ACC_W(ACC_W)) u_acc_abs (
      .clk  (clk),
      .reset(reset),
      .clr  (start),
      .load (take),
      .en   (add),
      .din  (abs_val),
      .acc  (acc_abs)
   );

   mer_accum #(.DIN_W(DATA_W), .ACC_W(ACC_W)) u_acc_sq (
      .clk  (clk),
      .reset(reset),
      .clr  (start),
      .load (take),
      .en   (add),
      .din  (sq_val),
      .acc  (acc_sq)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sym_cnt <= '0;
         err_cnt <= '0;
      end else if (start) begin
         sym_cnt <= take ? WIN_LOG2'(1) : '0;
         err_cnt <= (take && sym_error) ? (WIN_LOG2+1)'(1) : '0;
      end else if (add) begin
         sym_cnt <= sym_cnt + WIN_LOG2'(1);
         if (sym_error && err_cnt != ERR_MAX)
            err_cnt <= err_cnt + (WIN_LOG2+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_level     <= REF_INIT;
         err_power     <= '0;
         sym_err_count <= '0;
         result_valid  <= 1'b0;
      end else begin
         result_valid <= latch;
         if (latch) begin
            ref_level     <= $signed(DATA_W'(acc_abs >> WIN_LOG2));
            err_power     <= DATA_W'(acc_sq >> WIN_LOG2);
            sym_err_count <= err_cnt;
         end
      end
   end

endmodule
